// File: rtl/tof_arb_pkg.sv
// Shared types and helpers for the ToF sensor-to-BRAM write arbiter.
package tof_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } arb_state_e;

  localparam int N_SENSORS_DEF = 8;
  localparam int DATA_W_DEF    = 16;

  // Widest request vector the search helper handles.
  localparam int MAX_CH    = 32;
  localparam int MAX_IDX_W = 5;

  // First set bit of req[0 +: n] at or after start, searching upward with wrap;
  // -1 when nothing is requested. Scanning downward lets the lowest rotated
  // position overwrite every later match.
  function automatic int rr_first(input logic [MAX_CH-1:0] req, input int start, input int n);
    int res;
    int c;
    res = -1;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        c = start + k;
        if (c >= n) c = c - n;
        if (req[c[MAX_IDX_W-1:0]]) res = c;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tof_rr_picker.sv
// Combinational rotating priority encoder: picks the first requester at or
// after start, wrapping from N-1 back to 0.
module tof_rr_picker
  import tof_arb_pkg::*;
#(
  parameter int N     = N_SENSORS_DEF,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [MAX_CH-1:0] req_ext;
  int                pick;

  // NOTE: every signal driven here gets a default before any conditional use,
  // so the block stays purely combinational and no latch is inferred.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_first(req_ext, int'(start), N);
    valid          = (pick >= 0);
    idx            = valid ? IDX_W'(pick) : '0;
  end

endmodule

// File: rtl/tof_mem_arbiter.sv
// Round-robin arbiter sharing one BRAM write port between ToF sensor channels.
// Define TOF_ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest).
module tof_mem_arbiter
  import tof_arb_pkg::*;
#(
  parameter int N_SENSORS = N_SENSORS_DEF,
  parameter int IDX_W     = 3,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SLOT_AW   = 4,
  parameter int WR_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [N_SENSORS-1:0]      tof_dr,
  input  logic [N_SENSORS*DATA_W-1:0] tof_data,
  output logic [N_SENSORS-1:0]      tof_ack,
  output logic                      mem_wea,
  output logic [IDX_W+SLOT_AW-1:0]  mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  output logic [IDX_W-1:0]          tof_index,
  output logic                      busy
);

  localparam int               CNT_W    = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_CYCLES - 1);

  arb_state_e         state, state_nxt;
  logic [CNT_W-1:0]   wr_cnt;
  logic [SLOT_AW-1:0] wr_ptr [N_SENSORS];
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   pick_start;
  logic               grant;

`ifdef TOF_ARB_FIXED_PRIO_EN
  assign pick_start = '0;
`else
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (state == ACK) begin
      rr_ptr <= (tof_index == IDX_W'(N_SENSORS - 1)) ? '0 : tof_index + 1'b1;
    end
  end

  assign pick_start = rr_ptr;
`endif

  tof_rr_picker #(
    .N     (N_SENSORS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (tof_dr),
    .start (pick_start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && pick_valid) begin
          grant     = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE:   if (wr_cnt == CNT_LAST) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all sequential state is updated with non-blocking assignments so
  // every register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      tof_index <= '0;
      mem_din   <= '0;
      // NOTE: wr_ptr is a small flop array, not the sample BRAM, so it takes the
      // async reset like any other register.
      for (int i = 0; i < N_SENSORS; i++) wr_ptr[i] <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        tof_index <= pick_idx;
        mem_din   <= tof_data[pick_idx*DATA_W +: DATA_W];
      end
      if (state == WRITE) wr_cnt <= (wr_cnt == CNT_LAST) ? '0 : wr_cnt + 1'b1;
      else                wr_cnt <= '0;
      if (state == ACK) wr_ptr[tof_index] <= wr_ptr[tof_index] + 1'b1;
    end
  end

  // Outputs decode straight from state, so an async reset drops them at once.
  assign busy     = (state != IDLE);
  assign mem_wea  = (state == WRITE);
  assign mem_addr = mem_wea ? {tof_index, wr_ptr[tof_index]} : '0;
  assign tof_ack  = (state == ACK) ? (N_SENSORS'(1) << tof_index) : '0;

endmodule

// File: tb/tb_tof_mem_arbiter.sv
// Self-checking bench for tof_mem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level timing model.
module tb_tof_mem_arbiter;

  localparam int N         = 8;
  localparam int IDX_W     = 3;
  localparam int DATA_W    = 16;
  localparam int SLOT_AW   = 4;
  localparam int WR_CYCLES = 2;
  localparam int DEPTH     = 2 ** SLOT_AW;
`ifdef TOF_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     enable = 1'b0;
  logic [N-1:0]             tof_dr = '0;
  logic [N*DATA_W-1:0]      tof_data = '0;
  logic [N-1:0]             tof_ack;
  logic                     mem_wea;
  logic [IDX_W+SLOT_AW-1:0] mem_addr;
  logic [DATA_W-1:0]        mem_din;
  logic [IDX_W-1:0]         tof_index;
  logic                     busy;

  tof_mem_arbiter #(
    .N_SENSORS (N), .IDX_W (IDX_W), .DATA_W (DATA_W),
    .SLOT_AW (SLOT_AW), .WR_CYCLES (WR_CYCLES)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable), .tof_dr (tof_dr),
    .tof_data (tof_data), .tof_ack (tof_ack), .mem_wea (mem_wea),
    .mem_addr (mem_addr), .mem_din (mem_din), .tof_index (tof_index),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DATA_W-1:0] tb_mem [2**(IDX_W+SLOT_AW)];
  always @(posedge clk) if (mem_wea === 1'b1) tb_mem[mem_addr] <= mem_din;

  bit       auto_rearm = 1'b0;
  bit [N-1:0] rearm_pend = '0;

  // Reference: phase counts cycles since the grant (0 = idle).
  int m_phase, m_idx, m_rr, m_din;
  int m_ptr [N];
  logic                     exp_wea, exp_busy;
  logic [IDX_W+SLOT_AW-1:0] exp_addr;
  logic [N-1:0]             exp_ack;
  logic [DATA_W-1:0]        exp_din;
  logic [IDX_W-1:0]         exp_index;

  function automatic int first_ready(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++) if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    if ($countones(v) != 1) return -2;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -2;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_rr = 0; m_din = 0;
    for (int i = 0; i < N; i++) m_ptr[i] = 0;
  endtask

  task automatic model_step();
    if (!reset) model_reset();
    else if (m_phase == 0) begin
      if (enable && (|tof_dr)) begin
        m_idx   = first_ready(tof_dr, FIXED ? 0 : m_rr);
        m_din   = int'(tof_data[m_idx*DATA_W +: DATA_W]);
        m_phase = 1;
      end
    end else if (m_phase <= WR_CYCLES) m_phase++;
    else begin
      m_ptr[m_idx] = (m_ptr[m_idx] + 1) % DEPTH;
      m_rr         = (m_idx + 1) % N;
      m_phase      = 0;
    end
  endtask

  task automatic model_expect();
    exp_busy  = (m_phase != 0);
    exp_wea   = (m_phase >= 1) && (m_phase <= WR_CYCLES);
    exp_addr  = exp_wea ? (IDX_W+SLOT_AW)'(m_idx * DEPTH + m_ptr[m_idx]) : '0;
    exp_ack   = (m_phase == WR_CYCLES + 1) ? N'(1 << m_idx) : '0;
    exp_din   = DATA_W'(m_din);
    exp_index = IDX_W'(m_idx);
  endtask

  // One clock: model advances on the edge, outputs settle, sensors react to ack.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    model_expect();
    for (int i = 0; i < N; i++) if (rearm_pend[i]) begin
      tof_dr[i] = 1'b1;
      tof_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
    rearm_pend = '0;
    for (int i = 0; i < N; i++) if (tof_ack[i] === 1'b1) begin
      tof_dr[i] = 1'b0;
      if (auto_rearm) rearm_pend[i] = 1'b1;
    end
  endtask

  task automatic wait_ack(input int budget, output int idx, output int stamp);
    idx = -1;
    stamp = cyc;
    for (int t = 0; t < budget; t++) begin
      tick();
      if (tof_ack !== '0) begin
        idx = onehot_idx(tof_ack);
        stamp = cyc;
        return;
      end
    end
  endtask

  task automatic wait_wea(input int budget, output bit seen);
    seen = 1'b0;
    for (int t = 0; t < budget; t++) begin
      tick();
      if (mem_wea === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_reset(input logic [N-1:0] dr);
    reset = 1'b0;
    enable = 1'b1;
    tof_dr = dr;
    tof_data = {$urandom, $urandom, $urandom, $urandom};
    rearm_pend = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    int wea_cnt, first_wea, addr_bad, ack_tick;
    logic [N-1:0] ack_val;
    logic [DATA_W-1:0] din_seen, din_exp;
    auto_rearm = 1'b0;
    reset = 1'b0; enable = 1'b1; tof_dr = 8'hFF;
    tof_data = {$urandom, $urandom, $urandom, $urandom};
    din_exp = tof_data[DATA_W-1:0];
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({tof_ack, mem_wea, mem_addr, mem_din, tof_index, busy} !== '0)
      begin bad++; $display("FAIL reset_outputs got=%h exp=0", {tof_ack, mem_wea, mem_addr, mem_din, tof_index, busy}); end
    reset = 1'b1;
    wea_cnt = 0; first_wea = -1; addr_bad = 0; ack_tick = -1; ack_val = '0; din_seen = '0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (mem_wea === 1'b1) begin
        wea_cnt++;
        if (first_wea < 0) begin first_wea = t; din_seen = mem_din; end
        if (mem_addr !== '0) addr_bad++;
      end
      if (tof_ack !== '0 && ack_tick < 0) begin ack_tick = t; ack_val = tof_ack; end
      if (t == 4) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_after_ack busy=%b exp=0", busy); end
      end
    end
    total++;
    if (first_wea != 1 || wea_cnt != 2)
      begin bad++; $display("FAIL reset_first_write start=%0d cycles=%0d exp start=1 cycles=2", first_wea, wea_cnt); end
    total++;
    if (addr_bad != 0) begin bad++; $display("FAIL reset_first_addr bad_cycles=%0d exp=0", addr_bad); end
    total++;
    if (din_seen !== din_exp) begin bad++; $display("FAIL reset_first_din got=%h exp=%h", din_seen, din_exp); end
    total++;
    if (ack_tick != 3 || ack_val !== 8'h01)
      begin bad++; $display("FAIL reset_first_ack cycle=%0d val=%h exp cycle=3 val=01", ack_tick, ack_val); end
  endtask

  task automatic test_round_robin();
    int idx, st, exp;
    auto_rearm = 1'b1;
    do_reset(8'h81);
    for (int n = 0; n < 4; n++) begin
      wait_ack(20, idx, st);
      exp = FIXED ? 0 : ((n % 2) ? 7 : 0);
      total++;
      if (idx != exp) begin bad++; $display("FAIL rr_order n=%0d got=%0d exp=%0d", n, idx, exp); end
    end
    auto_rearm = 1'b0;
  endtask

  task automatic test_ring_wrap();
    int got_first, unstable, idx, st;
    logic [IDX_W+SLOT_AW-1:0] addr_first, addr_exp;
    auto_rearm = 1'b0;
    do_reset('0);
    for (int n = 0; n <= 16; n++) begin
      tof_data[3*DATA_W +: DATA_W] = DATA_W'(n);
      tof_dr[3] = 1'b1;
      got_first = 0; unstable = 0; addr_first = '0; idx = -1;
      for (int t = 0; t < 20 && idx < 0; t++) begin
        tick();
        if (mem_wea === 1'b1) begin
          if (!got_first) begin got_first = 1; addr_first = mem_addr; end
          else if (mem_addr !== addr_first) unstable++;
        end
        if (tof_ack !== '0) idx = onehot_idx(tof_ack);
      end
      addr_exp = 7'h30 + 7'(n % DEPTH);
      total++;
      if (!got_first || addr_first !== addr_exp || unstable != 0 || idx != 3)
        begin bad++; $display("FAIL wrap_addr n=%0d got=%h unstable=%0d ack=%0d exp=%h ack=3", n, addr_first, unstable, idx, addr_exp); end
    end
    tick();
    total++;
    if (tb_mem[7'h30] !== 16'd16) begin bad++; $display("FAIL wrap_overwrite got=%0d exp=16", tb_mem[7'h30]); end
    total++;
    if (tb_mem[7'h3F] !== 16'd15) begin bad++; $display("FAIL wrap_last_slot got=%0d exp=15", tb_mem[7'h3F]); end
  endtask

  task automatic test_disable();
    bit seen;
    int idx, st, grants;
    auto_rearm = 1'b1;
    do_reset('0);
    tof_dr = 8'h20;
    wait_wea(10, seen);
    enable = 1'b0;
    total++;
    if (!seen || tof_index !== 3'd5) begin bad++; $display("FAIL dis_grant seen=%0b idx=%0d exp seen=1 idx=5", seen, tof_index); end
    wait_ack(10, idx, st);
    total++;
    if (idx != 5) begin bad++; $display("FAIL dis_ack_completes got=%0d exp=5", idx); end
    grants = 0;
    repeat (8) begin
      tick();
      if (busy !== 1'b0 || mem_wea !== 1'b0) grants++;
    end
    total++;
    if (grants != 0) begin bad++; $display("FAIL dis_no_grant busy_cycles=%0d exp=0", grants); end
    enable = 1'b1;
    tick();
    total++;
    if (mem_wea !== 1'b1 || tof_index !== 3'd5)
      begin bad++; $display("FAIL dis_regrant wea=%b idx=%0d exp wea=1 idx=5", mem_wea, tof_index); end
    auto_rearm = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    int idx, st;
    auto_rearm = 1'b0;
    do_reset('0);
    tof_dr = 8'h04;
    wait_ack(10, idx, st);
    total++;
    if (idx != 2) begin bad++; $display("FAIL mid_first_ack got=%0d exp=2", idx); end
    tick();
    tof_dr = 8'h04;
    wait_wea(10, seen);
    #2 reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (!seen || mem_wea !== 1'b0 || busy !== 1'b0 || mem_addr !== '0)
      begin bad++; $display("FAIL mid_abort seen=%0b wea=%b busy=%b addr=%h exp 1/0/0/00", seen, mem_wea, busy, mem_addr); end
    @(posedge clk);
    #1 reset = 1'b1;
    tof_dr = 8'h05;
    wait_wea(10, seen);
    total++;
    if (!seen || tof_index !== 3'd0 || mem_addr !== 7'h00)
      begin bad++; $display("FAIL mid_rr_cleared idx=%0d addr=%h exp idx=0 addr=00", tof_index, mem_addr); end
    wait_ack(10, idx, st);
    wait_wea(10, seen);
    total++;
    if (!seen || mem_addr !== 7'h20)
      begin bad++; $display("FAIL mid_wrptr_cleared addr=%h exp=20", mem_addr); end
  endtask

  task automatic test_throughput();
    int idx, exp;
    int st [8];
    auto_rearm = 1'b1;
    do_reset(8'hFF);
    for (int n = 0; n < 8; n++) begin
      wait_ack(20, idx, st[n]);
      exp = FIXED ? 0 : n;
      total++;
      if (idx != exp) begin bad++; $display("FAIL tput_order n=%0d got=%0d exp=%0d", n, idx, exp); end
    end
    for (int n = 1; n < 8; n++) begin
      total++;
      if (st[n] - st[n-1] != WR_CYCLES + 2)
        begin bad++; $display("FAIL tput_interval n=%0d got=%0d exp=%0d", n, st[n] - st[n-1], WR_CYCLES + 2); end
    end
    auto_rearm = 1'b0;
  endtask

  task automatic test_random();
    auto_rearm = 1'b0;
    do_reset(N'($urandom));
    for (int t = 0; t < 600; t++) begin
      tick();
      total++;
      if (mem_wea !== exp_wea) begin bad++; $display("FAIL rand_wea cyc=%0d got=%b exp=%b", cyc, mem_wea, exp_wea); end
      total++;
      if (mem_addr !== exp_addr) begin bad++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_addr); end
      total++;
      if (tof_ack !== exp_ack) begin bad++; $display("FAIL rand_ack cyc=%0d got=%h exp=%h", cyc, tof_ack, exp_ack); end
      total++;
      if (mem_din !== exp_din) begin bad++; $display("FAIL rand_din cyc=%0d got=%h exp=%h", cyc, mem_din, exp_din); end
      total++;
      if (tof_index !== exp_index) begin bad++; $display("FAIL rand_index cyc=%0d got=%0d exp=%0d", cyc, tof_index, exp_index); end
      total++;
      if (busy !== exp_busy) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      enable = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        if (!tof_dr[i]) begin
          tof_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
          if ($urandom_range(0, 3) == 0) tof_dr[i] = 1'b1;
        end else if ($urandom_range(0, 15) == 0) tof_dr[i] = 1'b0;
      end
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b0;
        model_reset();
        #1;
        total++;
        if ({mem_wea, busy, tof_ack} !== '0)
          begin bad++; $display("FAIL rand_async_reset cyc=%0d got=%h exp=0", cyc, {mem_wea, busy, tof_ack}); end
        @(negedge clk) reset = 1'b1;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_ring_wrap();
    test_disable();
    test_reset_mid_write();
    test_throughput();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
